// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, ID width helper
// and the default store-in-flight limit.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_OUT_STORES = 7;

  // Memory-side ID is {port index, requester tid}.
  function automatic int mem_arb_idw(input int nr_ports, input int tid_w);
    return $clog2(nr_ports) + tid_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible index at or after the
// pointer, wrapping to the lowest eligible index below it.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] win_o,
  output logic          vld_o
);

  logic [PW-1:0] w_lo;
  logic [PW-1:0] w_hi;
  logic          w_hi_vld;

  // Scanning downward leaves the lowest matching index in each candidate.
  always_comb begin
    w_lo     = '0;
    w_hi     = '0;
    w_hi_vld = 1'b0;
    vld_o    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig_i[k]) begin
        w_lo  = PW'(k);
        vld_o = 1'b1;
        if (PW'(k) >= ptr_i) begin
          w_hi     = PW'(k);
          w_hi_vld = 1'b1;
        end
      end
    end
    win_o = w_hi_vld ? w_hi : w_lo;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request port among NR_PORTS requesters.
// Optional stall counter enabled by defining MEM_ARB_STALL_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NR_PORTS       = 3,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TID_W          = 2,
  parameter int MAX_OUT_STORES = DEF_MAX_OUT_STORES,
  localparam int IDW           = mem_arb_idw(NR_PORTS, TID_W),
  localparam int SW            = $clog2(MAX_OUT_STORES + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_PORTS-1:0]                req_valid_i,
  output logic [NR_PORTS-1:0]                req_ready_o,
  input  logic [NR_PORTS-1:0]                req_we_i,
  input  logic [NR_PORTS-1:0][ADDR_W-1:0]    req_addr_i,
  input  logic [NR_PORTS-1:0][DATA_W-1:0]    req_wdata_i,
  input  logic [NR_PORTS-1:0][TID_W-1:0]     req_tid_i,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic                               mem_req_we_o,
  output logic [ADDR_W-1:0]                  mem_req_addr_o,
  output logic [DATA_W-1:0]                  mem_req_wdata_o,
  output logic [IDW-1:0]                     mem_req_id_o,
  input  logic                               mem_rsp_valid_i,
  input  logic [IDW-1:0]                     mem_rsp_id_i,
  input  logic                               mem_rsp_store_i,
  input  logic [DATA_W-1:0]                  mem_rsp_rdata_i,
  output logic [NR_PORTS-1:0]                rsp_valid_o,
  output logic [TID_W-1:0]                   rsp_tid_o,
  output logic [DATA_W-1:0]                  rsp_rdata_o,
  output logic [SW-1:0]                      stores_out_o,
  output logic [31:0]                        stall_cnt_o
);

  localparam int PW = $clog2(NR_PORTS);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_ptr_nxt;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_req_port;
  logic [PW-1:0]       w_rsp_port;
  logic [NR_PORTS-1:0] w_elig;
  logic                w_pick_vld;
  logic                w_capture;
  logic                w_mem_hs;
  logic                w_st_room;
  logic                w_st_inc;
  logic                w_st_dec;
  logic [SW-1:0]       r_stores;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDW-1:0]      r_id;

  // Stores are held back at the in-flight limit; loads always stay eligible.
  assign w_st_room = (r_stores < SW'(MAX_OUT_STORES));
  assign w_elig    = req_valid_i & (~req_we_i | {NR_PORTS{w_st_room}});

  rr_pick #(
    .N  (NR_PORTS),
    .PW (PW)
  ) u_rr_pick (
    .elig_i (w_elig),
    .ptr_i  (r_ptr),
    .win_o  (w_win),
    .vld_o  (w_pick_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst_i) w_capture = 1'b0;
  end

  assign req_ready_o     = w_capture ? (NR_PORTS'(1) << w_win) : '0;
  assign mem_req_valid_o = (r_state == ISSUE);
  assign w_mem_hs        = mem_req_valid_o & mem_req_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_we    <= req_we_i[w_win];
      r_addr  <= req_addr_i[w_win];
      r_wdata <= req_wdata_i[w_win];
      r_id    <= {w_win, req_tid_i[w_win]};
    end
  end

  assign mem_req_we_o    = r_we;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_wdata_o = r_wdata;
  assign mem_req_id_o    = r_id;

  assign w_req_port = r_id[IDW-1:TID_W];
  assign w_ptr_nxt  = (w_req_port == PW'(NR_PORTS - 1)) ? '0 : w_req_port + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_ptr <= '0;
    else if (w_mem_hs) r_ptr <= w_ptr_nxt;
  end

  assign w_st_inc = w_mem_hs & r_we;
  assign w_st_dec = mem_rsp_valid_i & mem_rsp_store_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stores <= '0;
    end else if (w_st_inc && !w_st_dec && (r_stores != SW'(MAX_OUT_STORES))) begin
      r_stores <= r_stores + 1'b1;
    end else if (w_st_dec && !w_st_inc && (r_stores != '0)) begin
      r_stores <= r_stores - 1'b1;
    end
  end

  assign stores_out_o = r_stores;

  // Responses with an out-of-range port field match no port and are dropped.
  assign w_rsp_port = mem_rsp_id_i[IDW-1:TID_W];

  always_comb begin
    rsp_valid_o = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (mem_rsp_valid_i && !rst_i && (w_rsp_port == PW'(p))) rsp_valid_o[p] = 1'b1;
    end
  end

  assign rsp_tid_o   = mem_rsp_id_i[TID_W-1:0];
  assign rsp_rdata_o = mem_rsp_rdata_i;

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                 r_stall_cnt <= '0;
    else if ((|req_valid_i) && !(|req_ready_o)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NR_PORTS, default 3, number of requesters (0 = icache refill, 1 = dcache read, 2 = dcache write buffer).
REQ-002 SHALL have parameter ADDR_W, default 64, request address width.
REQ-003 SHALL have parameter DATA_W, default 64, write and read data width.
REQ-004 SHALL have parameter TID_W, default 2, requester transaction-ID width.
REQ-005 SHALL have parameter MAX_OUT_STORES, default 7, maximum number of stores in flight.
REQ-006 SHALL have clk_i  in  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-008 SHALL have req_valid_i / req_ready_o  in / out  NR_PORTS  per-port request handshake.
REQ-009 SHALL have req_we_i  in  NR_PORTS  per-port store flag.
REQ-010 SHALL have req_addr_i, req_wdata_i, req_tid_i  in  NR_PORTS x ADDR_W / DATA_W / TID_W  per-port payload.
REQ-011 SHALL have mem_req_valid_o / mem_req_ready_i  out / in  1  shared memory-port request handshake.
REQ-012 SHALL have mem_req_we_o, mem_req_addr_o, mem_req_wdata_o  out  1 / ADDR_W / DATA_W  granted payload.
REQ-013 SHALL have mem_req_id_o  out  IDW = clog2(NR_PORTS)+TID_W  ID = {port index, tid}.
REQ-014 SHALL have mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_store_i, mem_rsp_rdata_i  in  1 / IDW / 1 / DATA_W  response channel; the memory side has no backpressure.
REQ-015 SHALL have rsp_valid_o, rsp_tid_o, rsp_rdata_o  out  NR_PORTS / TID_W / DATA_W  per-port response routing.
REQ-016 SHALL have stores_out_o  out  clog2(MAX_OUT_STORES+1)  count of stores in flight.
REQ-017 SHALL have stall_cnt_o  out  32  arbitration-stall counter (see Configuration).

Function
REQ-018 SHALL implement a two-state FSM, IDLE and ISSUE; it SHALL reset to IDLE.
REQ-019 IDLE: on any eligible request, SHALL register the round-robin winner and its payload and move to ISSUE on the next cycle, giving 1-cycle latency from req_valid_i to mem_req_valid_o.
REQ-020 A request is eligible when req_valid_i is high and it is either a load, or a store with stores_out_o < MAX_OUT_STORES.
REQ-021 SHALL pulse req_ready_o of the winner in the cycle it is captured; only one req_ready_o SHALL be high per cycle.
REQ-022 ISSUE: mem_req_valid_o and the payload SHALL be held stable until mem_req_ready_i; on the handshake the FSM SHALL return to IDLE.
REQ-023 The round-robin pointer SHALL move to winner+1 (mod NR_PORTS) on each handshake; the search SHALL start at the pointer; ties go to the lowest index at or after the pointer.
REQ-024 The store counter SHALL increment on a store handshake and decrement on mem_rsp_valid_i with mem_rsp_store_i.
REQ-025 When an increment and a decrement occur in the same cycle, the counter SHALL be unchanged.
REQ-026 The store counter SHALL never exceed MAX_OUT_STORES and SHALL saturate at 0 on a spurious decrement.
REQ-027 Responses: rsp_valid_o[mem_rsp_id_i port field] SHALL follow mem_rsp_valid_i combinationally, with rsp_tid_o and rsp_rdata_o passed through.
REQ-028 A response whose port field is >= NR_PORTS SHALL be dropped.
REQ-029 Loads SHALL never be blocked by the store limit.

Reset
REQ-030 While rst_i is high, the following SHALL be 0 from the next edge: FSM state (IDLE), round-robin pointer, store counter, mem_req_valid_o, req_ready_o, rsp_valid_o and stall_cnt_o.
REQ-031 Reset asserted during ISSUE SHALL drop mem_req_valid_o without waiting for mem_req_ready_i.

Configuration
REQ-032 With MEM_ARB_STALL_CNT_EN defined, stall_cnt_o SHALL increment (wrapping at 2^32) in every cycle where some req_valid_i is high and no req_ready_o is asserted.
REQ-033 Without MEM_ARB_STALL_CNT_EN, stall_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-034 A shared package mem_arb_pkg SHALL hold the FSM state enum, the IDW computation function and the default MAX_OUT_STORES constant.
REQ-035 The round-robin priority search SHALL be one sub-module, rr_pick, which is combinational: inputs are an eligible mask and a pointer, outputs are a winner index and a valid flag.

Verification
REQ-036 The bench SHALL check that port 1 loading with mem_req_ready_i=1 gives mem_req_valid_o high 1 cycle after req_valid_i, with mem_req_id_o={2'd1,tid}.
REQ-037 The bench SHALL check that all three ports requesting continuously with ready=1 are granted in the order 0,1,2,0,1,2.
REQ-038 The bench SHALL check that with 7 stores issued and no responses, a port-2 store stays stalled while a port-0 load is granted; one store response then lets the store issue.
REQ-039 The bench SHALL check that a simultaneous store handshake and store response at count 3 leaves stores_out_o at 3.
REQ-040 The bench SHALL check that holding mem_req_ready_i=0 for 5 cycles keeps the payload stable, and that rst_i in cycle 3 clears mem_req_valid_o on the next edge.
REQ-041 The bench SHALL check that, with MEM_ARB_STALL_CNT_EN defined, 4 cycles of pending requests during ISSUE give stall_cnt_o=4, and that without the macro stall_cnt_o stays 0.
